btn_sw_input_conditioner: RTL and testbench

- Input-side counterpart to the display output path: conditions raw board buttons and switches before they reach the CPU and the top level.
- Per button: 2-FF synchronizer, debounce FSM, one-cycle press/release pulses and optional auto-repeat.
- Switches: synchronized, sample-debounced, with a change pulse.
- Buttons are active-low at the pin (pressed = 0); every output of this block is active-high.

---
 rtl/btn_sw_input_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_btn_sw_input_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_sw_input_conditioner.sv
// Input conditioner for raw board buttons and switches.
// Buttons: 2-FF synchronizer, debounce FSM, press/release pulses, optional auto-repeat.
// Switches: 2-FF synchronizer, tick-sampled debounce, change pulse on any accepted update.
// Buttons are active-low at the pin; all outputs are active-high.
module btn_sw_input_conditioner #(
  parameter int unsigned N_BTN    = 2,
  parameter int unsigned N_SW     = 10,
  parameter int unsigned DB_CYC   = 500000,
  parameter int unsigned HOLD_CYC = 25000000,
  parameter int unsigned RPT_CYC  = 5000000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_BTN-1:0] RPT_EN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_SW-1:0]  SW_DB,
  output logic             SW_CHG
);

  typedef enum logic [2:0] {StRel, StPdb, StHeld, StRpt, StRdb} btn_state_e;

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RptLast  = CNT_W'(RPT_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] btn_sync1_q, btn_sync2_q;

  // Button synchronizer; resets to the released (high) pin level
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      btn_sync1_q <= '1;
      btn_sync2_q <= '1;
    end else begin
      btn_sync1_q <= BTN;
      btn_sync2_q <= btn_sync1_q;
    end
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             p;

    assign p = ~btn_sync2_q[i];

    // Debounce / repeat next-state; cnt clears on every state entry and on each repeat
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntOne;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        StRel: begin
          cnt_d = '0;
          if (p) state_d = StPdb;
        end
        StPdb: begin
          if (!p) begin
            state_d = StRel;
            cnt_d   = '0;
          end else if (cnt_q == DbLast) begin
            state_d = StHeld;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end
        end
        StHeld: begin
          if (!p) begin
            state_d = StRdb;
            cnt_d   = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = StRpt;
            cnt_d   = '0;
            press_d = RPT_EN[i];
          end
        end
        StRpt: begin
          if (!p) begin
            state_d = StRdb;
            cnt_d   = '0;
          end else if (cnt_q == RptLast) begin
            cnt_d   = '0;
            press_d = RPT_EN[i];
          end
        end
        StRdb: begin
          // A bounce back to pressed restarts the hold interval without a pulse
          if (p) begin
            state_d = StHeld;
            cnt_d   = '0;
          end else if (cnt_q == DbLast) begin
            state_d = StRel;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end
        end
        default: begin
          state_d = StRel;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    // Per-button state, counter and registered outputs
    always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= StRel;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign BTN_LEVEL[i]   = level_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = rel_q;
  end

  // ---------------------------------------------------------------------------
  // Switch path
  // ---------------------------------------------------------------------------
  logic [N_SW-1:0]  sw_sync1_q, sw_sync2_q;
  logic [N_SW-1:0]  sw_last_q, sw_last_d;
  logic [N_SW-1:0]  sw_db_q, sw_db_d;
  logic             sw_chg_q, sw_chg_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // Tick every DB_CYC cycles; accept a vector seen on two consecutive ticks
  always_comb begin
    tick       = (tick_cnt_q == DbLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CntOne;
    sw_last_d  = sw_last_q;
    sw_db_d    = sw_db_q;
    sw_chg_d   = 1'b0;
    if (tick) begin
      sw_last_d = sw_sync2_q;
      if ((sw_sync2_q == sw_last_q) && (sw_sync2_q != sw_db_q)) begin
        sw_db_d  = sw_sync2_q;
        sw_chg_d = 1'b1;
      end
    end
  end

  // Switch synchronizer, sample history, debounced value and change pulse
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      sw_last_q  <= '0;
      sw_db_q    <= '0;
      sw_chg_q   <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
      sw_last_q  <= sw_last_d;
      sw_db_q    <= sw_db_d;
      sw_chg_q   <= sw_chg_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign SW_DB  = sw_db_q;
  assign SW_CHG = sw_chg_q;

endmodule

// File: tb/tb_btn_sw_input_conditioner.sv
// Directed bench for btn_sw_input_conditioner with DB_CYC=4, HOLD_CYC=10, RPT_CYC=3.
module tb_btn_sw_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn;
  logic [9:0] sw;
  logic [1:0] rpt_en;
  logic [1:0] btn_level, btn_press, btn_release;
  logic [9:0] sw_db;
  logic       sw_chg;

  int n_checks = 0;
  int n_err    = 0;

  btn_sw_input_conditioner #(
    .N_BTN   (2),
    .N_SW    (10),
    .DB_CYC  (4),
    .HOLD_CYC(10),
    .RPT_CYC (3),
    .CNT_W   (8)
  ) dut (
    .CLK1       (clk),
    .RST_N      (rst_n),
    .BTN        (btn),
    .SW         (sw),
    .RPT_EN     (rpt_en),
    .BTN_LEVEL  (btn_level),
    .BTN_PRESS  (btn_press),
    .BTN_RELEASE(btn_release),
    .SW_DB      (sw_db),
    .SW_CHG     (sw_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         idx;
    logic [1:0] btn;
    logic [1:0] rpt;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input int idx, input logic [1:0] b, input logic [1:0] r,
                     input logic [1:0] l, input logic [1:0] p, input logic [1:0] rl);
    vec_t v;
    v.tag = tag; v.idx = idx; v.btn = b; v.rpt = r; v.lvl = l; v.prs = p; v.rel = rl;
    vecs.push_back(v);
  endtask

  function automatic bit in_set(input int j, input int s[]);
    foreach (s[k]) if (s[k] == j) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_table();
    int rpt_pts[] = '{6, 16, 19, 22, 25, 28, 31};
    // A: BTN[0] held 30 cycles with repeat; release seen 2+DB_CYC cycles after the rise
    for (int j = 0; j < 40; j++)
      add("repeat", j, (j < 30) ? 2'b10 : 2'b11, 2'b01,
          {1'b0, (j >= 6 && j < 36)}, {1'b0, in_set(j, rpt_pts)}, {1'b0, j == 36});
    // B: same stimulus, repeat disabled -> only the debounced press
    for (int j = 0; j < 40; j++)
      add("norpt", j, (j < 30) ? 2'b10 : 2'b11, 2'b00,
          {1'b0, (j >= 6 && j < 36)}, {1'b0, j == 6}, {1'b0, j == 36});
    // C: 3-cycle low glitch is rejected
    for (int j = 0; j < 12; j++)
      add("glitch", j, (j < 3) ? 2'b10 : 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    // D: release bounce (high, low, high) -> a single release after the final rise settles
    for (int j = 0; j < 24; j++)
      add("bounce", j, (j < 10 || j == 11) ? 2'b10 : 2'b11, 2'b00,
          {1'b0, (j >= 6 && j < 18)}, {1'b0, j == 6}, {1'b0, j == 18});
    // E: both pressed together; BTN[1] released while BTN[0] repeats
    for (int j = 0; j < 40; j++)
      add("simul", j, {(j >= 18), (j >= 30)}, 2'b01,
          {(j >= 6 && j < 24), (j >= 6 && j < 36)},
          {j == 6, in_set(j, rpt_pts)},
          {j == 24, j == 36});
  endtask

  initial begin
    int first;
    int nchg;

    rst_n  = 1'b0;
    btn    = 2'b11;
    sw     = '0;
    rpt_en = 2'b00;
    build_table();

    // Reset state
    step(); step(); step();
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_press", 32'(btn_press), 32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_sw_db", 32'(sw_db), 32'h0);
    check("rst_sw_chg", 32'(sw_chg), 32'h0);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) step();
    check("idle_level", 32'(btn_level), 32'h0);

    // Table-driven button sequences
    foreach (vecs[i]) begin
      btn    = vecs[i].btn;
      rpt_en = vecs[i].rpt;
      step();
      check($sformatf("%s[%0d].level", vecs[i].tag, vecs[i].idx), 32'(btn_level), 32'(vecs[i].lvl));
      check($sformatf("%s[%0d].press", vecs[i].tag, vecs[i].idx), 32'(btn_press), 32'(vecs[i].prs));
      check($sformatf("%s[%0d].release", vecs[i].tag, vecs[i].idx), 32'(btn_release),
            32'(vecs[i].rel));
    end
    check("btn_sw_db_quiet", 32'(sw_db), 32'h0);

    // Reset during press debounce, button still held afterwards
    btn    = 2'b10;
    rpt_en = 2'b01;
    for (int j = 0; j < 4; j++) step();
    rst_n = 1'b0;
    #1;
    check("rst_pdb_level", 32'(btn_level), 32'h0);
    check("rst_pdb_press", 32'(btn_press), 32'h0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      check($sformatf("post_rst[%0d].press", j), 32'(btn_press),
            32'(in_set(j, '{6, 16, 19})));
      check($sformatf("post_rst[%0d].level", j), 32'(btn_level), 32'(j >= 6));
    end
    // Reset during a repeat pulse clears outputs without waiting for a clock edge
    rst_n = 1'b0;
    #1;
    check("rst_rpt_press", 32'(btn_press), 32'h0);
    check("rst_rpt_level", 32'(btn_level), 32'h0);
    btn = 2'b11;
    step(); step();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) step();
    check("post_rst_idle", 32'({btn_level, btn_press, btn_release}), 32'h0);

    // Switch accepted after two equal ticks, one change pulse
    sw = 10'h005; first = -1; nchg = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (sw_chg) begin
        nchg++;
        if (first < 0) first = j;
        check("sw_db_at_chg", 32'(sw_db), 32'h005);
      end
    end
    check("sw_chg_count", 32'(nchg), 32'd1);
    check("sw_chg_latency_ok", 32'(first >= 7 && first <= 10), 32'd1);
    check("sw_db_005", 32'(sw_db), 32'h005);

    // Bit toggling every tick never gives two equal samples
    nchg = 0;
    for (int j = 0; j < 40; j++) begin
      if (j % 4 == 0) sw[1] = ~sw[1];
      step();
      if (sw_chg) nchg++;
    end
    for (int j = 0; j < 12; j++) begin
      step();
      if (sw_chg) nchg++;
    end
    check("sw_toggle_chg", 32'(nchg), 32'd0);
    check("sw_toggle_db", 32'(sw_db), 32'h005);

    // Second accepted value
    sw = 10'h3fa; nchg = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (sw_chg) nchg++;
    end
    check("sw_chg_count2", 32'(nchg), 32'd1);
    check("sw_db_3fa", 32'(sw_db), 32'h3fa);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
